// File: rtl/vote_result_reader.sv
// Snapshots four candidate tallies on start and streams header, tallies and checksum over valid/ready.
// Define VOTE_RESULT_WINNER_EN to insert a winner-index byte ahead of the checksum.
module vote_result_reader #(
  parameter logic [7:0] HEADER_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       start,
  input  logic [7:0] cand1_votes,
  input  logic [7:0] cand2_votes,
  input  logic [7:0] cand3_votes,
  input  logic [7:0] cand4_votes,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // state  | meaning
  // S_IDLE | waiting for start with mode=1
  // S_HDR  | presenting HEADER_BYTE
  // S_C1.. | presenting snapshot tally 1..4
  // S_WIN  | presenting winner index (winner build only)
  // S_CSUM | presenting checksum of tallies (+winner)
`ifdef VOTE_RESULT_WINNER_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_C1, S_C2, S_C3, S_C4, S_WIN, S_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_C1, S_C2, S_C3, S_C4, S_CSUM
  } state_t;
`endif

  // Stall timer counts down from TIMEOUT_CYCLES-1; a stall seen at zero is the last one allowed.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [7:0]       snap1, snap2, snap3, snap4;
  logic [CNT_W-1:0] stall_cnt;
  logic             xfer, stall, timeout, accept;
  logic [7:0]       csum;

  assign xfer    = tx_valid & tx_ready;
  assign stall   = tx_valid & ~tx_ready;
  assign timeout = stall && (stall_cnt == '0);
  assign accept  = (state == S_IDLE) && start && mode;

`ifdef VOTE_RESULT_WINNER_EN
  logic [7:0] win_byte;
  logic [7:0] best_val;

  // Strict greater-than keeps ties on the lowest index.
  always_comb begin
    best_val = snap1;
    win_byte = 8'd1;
    if (snap2 > best_val) begin
      best_val = snap2;
      win_byte = 8'd2;
    end
    if (snap3 > best_val) begin
      best_val = snap3;
      win_byte = 8'd3;
    end
    if (snap4 > best_val) begin
      best_val = snap4;
      win_byte = 8'd4;
    end
    if (best_val == 8'd0) win_byte = 8'd0;
  end

  assign csum = snap1 + snap2 + snap3 + snap4 + win_byte;
`else
  assign csum = snap1 + snap2 + snap3 + snap4;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      snap1     <= 8'd0;
      snap2     <= 8'd0;
      snap3     <= 8'd0;
      snap4     <= 8'd0;
      stall_cnt <= STALL_RELOAD;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        snap1 <= cand1_votes;
        snap2 <= cand2_votes;
        snap3 <= cand3_votes;
        snap4 <= cand4_votes;
      end
      if (stall && (stall_cnt != '0)) stall_cnt <= stall_cnt - 1'b1;
      else                            stall_cnt <= STALL_RELOAD;
      done  <= (state == S_CSUM) && xfer;
      error <= timeout;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_HDR;
      S_HDR:  if (xfer)   state_nxt = S_C1;
      S_C1:   if (xfer)   state_nxt = S_C2;
      S_C2:   if (xfer)   state_nxt = S_C3;
      S_C3:   if (xfer)   state_nxt = S_C4;
`ifdef VOTE_RESULT_WINNER_EN
      S_C4:   if (xfer)   state_nxt = S_WIN;
      S_WIN:  if (xfer)   state_nxt = S_CSUM;
`else
      S_C4:   if (xfer)   state_nxt = S_CSUM;
`endif
      S_CSUM: if (xfer)   state_nxt = S_IDLE;
      default:            state_nxt = S_IDLE;
    endcase
    if (timeout) state_nxt = S_IDLE;
  end

  always_comb begin
    tx_valid = (state != S_IDLE);
    busy     = (state != S_IDLE);
    tx_data  = 8'd0;
    case (state)
      S_HDR:  tx_data = HEADER_BYTE;
      S_C1:   tx_data = snap1;
      S_C2:   tx_data = snap2;
      S_C3:   tx_data = snap3;
      S_C4:   tx_data = snap4;
`ifdef VOTE_RESULT_WINNER_EN
      S_WIN:  tx_data = win_byte;
`endif
      S_CSUM: tx_data = csum;
      default: tx_data = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_vote_result_reader.sv
// Directed bench for vote_result_reader: table of frames plus timeout, reset and back-to-back sequences.
module tb_vote_result_reader;

  localparam int TO = 4;

  logic       clock = 1'b0;
  logic       reset, mode, start, tx_ready;
  logic [7:0] c1, c2, c3, c4;
  logic [7:0] tx_data;
  logic       tx_valid, busy, done, error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_bytes[7];
  int         nb;

  typedef struct {
    logic [7:0] c1, c2, c3, c4;
    bit         toggle;
    bit         disturb;
    logic [7:0] win;
    logic [7:0] csum_nw;
    logic [7:0] csum_w;
  } vec_t;

  vec_t vecs[7];

  vote_result_reader #(.HEADER_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .mode(mode), .start(start),
    .cand1_votes(c1), .cand2_votes(c2), .cand3_votes(c3), .cand4_votes(c4),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_vec(input int i);
    c1 = vecs[i].c1; c2 = vecs[i].c2; c3 = vecs[i].c3; c4 = vecs[i].c4;
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = vecs[i].c1;
    exp_bytes[2] = vecs[i].c2;
    exp_bytes[3] = vecs[i].c3;
    exp_bytes[4] = vecs[i].c4;
`ifdef VOTE_RESULT_WINNER_EN
    exp_bytes[5] = vecs[i].win;
    exp_bytes[6] = vecs[i].csum_w;
    nb = 7;
`else
    exp_bytes[5] = vecs[i].csum_nw;
    exp_bytes[6] = 8'h00;
    nb = 6;
`endif
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_frame();
    start = 1'b1;
    mode  = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic collect(input bit toggle, input bit disturb);
    int         idx = 0;
    int         cyc = 0;
    bit         stalled = 1'b0;
    logic [7:0] held = 8'h00;
    check("latency_valid", {31'd0, tx_valid}, 32'd1);
    check("latency_hdr", {24'd0, tx_data}, 32'hA5);
    while (idx < nb && cyc < 200) begin
      check("valid_hold", {31'd0, tx_valid}, 32'd1);
      if (stalled) check("stable_data", {24'd0, tx_data}, {24'd0, held});
      tx_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (disturb && idx == 2) begin
        start = 1'b1; mode = 1'b1;
        c1 = 8'h11; c2 = 8'h22; c3 = 8'h33; c4 = 8'h44;
      end
      if (disturb && idx == 4) mode = 1'b0;
      if (tx_valid && tx_ready) begin
        check($sformatf("byte%0d", idx), {24'd0, tx_data}, {24'd0, exp_bytes[idx]});
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = tx_valid;
        held    = tx_data;
      end
      cyc++;
      @(negedge clock);
    end
    if (idx < nb) check("frame_budget", idx, nb);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("no_error", {31'd0, error}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("valid_after", {31'd0, tx_valid}, 32'd0);
    check("data_after", {24'd0, tx_data}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{c1:8'd3,   c2:8'd7,   c3:8'd0,  c4:8'd255, toggle:0, disturb:0, win:8'd4, csum_nw:8'h09, csum_w:8'h0D};
    vecs[1] = '{c1:8'd3,   c2:8'd7,   c3:8'd0,  c4:8'd255, toggle:1, disturb:0, win:8'd4, csum_nw:8'h09, csum_w:8'h0D};
    vecs[2] = '{c1:8'd5,   c2:8'd5,   c3:8'd2,  c4:8'd1,   toggle:0, disturb:0, win:8'd1, csum_nw:8'h0D, csum_w:8'h0E};
    vecs[3] = '{c1:8'd0,   c2:8'd0,   c3:8'd0,  c4:8'd0,   toggle:1, disturb:0, win:8'd0, csum_nw:8'h00, csum_w:8'h00};
    vecs[4] = '{c1:8'd10,  c2:8'd20,  c3:8'd30, c4:8'd40,  toggle:0, disturb:1, win:8'd4, csum_nw:8'h64, csum_w:8'h68};
    vecs[5] = '{c1:8'd200, c2:8'd100, c3:8'd50, c4:8'd25,  toggle:1, disturb:0, win:8'd1, csum_nw:8'h77, csum_w:8'h78};
    vecs[6] = '{c1:8'd1,   c2:8'd9,   c3:8'd9,  c4:8'd2,   toggle:0, disturb:0, win:8'd2, csum_nw:8'h15, csum_w:8'h17};

    reset = 1'b1; mode = 1'b0; start = 1'b0; tx_ready = 1'b0;
    c1 = 8'd0; c2 = 8'd0; c3 = 8'd0; c4 = 8'd0;
    repeat (2) @(negedge clock);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // start with mode=0 is ignored
    c1 = 8'd9; mode = 1'b0; start = 1'b1;
    repeat (3) @(negedge clock);
    check("mode0_busy", {31'd0, busy}, 32'd0);
    check("mode0_valid", {31'd0, tx_valid}, 32'd0);
    start = 1'b0; mode = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) begin
      load_vec(i);
      start_frame();
      collect(vecs[i].toggle, vecs[i].disturb);
      if (vecs[i].disturb) begin
        @(negedge clock);
        check("start_mode0_after_done", {31'd0, busy}, 32'd0);
        start = 1'b0; mode = 1'b1;
      end
      tx_ready = 1'b1;
      @(negedge clock);
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end

    // start accepted in the cycle done is high
    load_vec(0);
    start_frame();
    collect(1'b0, 1'b0);
    start_frame();
    collect(1'b0, 1'b0);
    @(negedge clock);

    // timeout: header accepted, then sink stalls on C1
    load_vec(0);
    start_frame();
    tx_ready = 1'b1;
    @(negedge clock);
    tx_ready = 1'b0;
    for (int k = 0; k < TO; k++) begin
      check("to_valid", {31'd0, tx_valid}, 32'd1);
      check("to_c1_held", {24'd0, tx_data}, 32'h03);
      @(negedge clock);
    end
    check("to_error", {31'd0, error}, 32'd1);
    check("to_done", {31'd0, done}, 32'd0);
    check("to_valid_low", {31'd0, tx_valid}, 32'd0);
    check("to_busy_low", {31'd0, busy}, 32'd0);
    check("to_data_zero", {24'd0, tx_data}, 32'd0);
    @(negedge clock);
    check("to_error_pulse", {31'd0, error}, 32'd0);
    check("to_no_late_done", {31'd0, done}, 32'd0);

    // async reset while C2 is on the bus
    tx_ready = 1'b1;
    load_vec(0);
    start_frame();
    @(negedge clock);
    @(negedge clock);
    check("pre_reset_c2", {24'd0, tx_data}, 32'h07);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, tx_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_data", {24'd0, tx_data}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_error", {31'd0, error}, 32'd0);
    @(negedge clock);
    check("arst_no_done", {31'd0, done}, 32'd0);
    check("arst_no_error", {31'd0, error}, 32'd0);
    load_vec(2);
    start_frame();
    collect(1'b0, 1'b0);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
